// File: rtl/simd_issuer.sv
// Issues a 16-entry instruction program to a fixed-latency SIMD core and queues its results,
// using credits so that every in-flight result is guaranteed a slot in the 4-entry result FIFO.
module simd_issuer #(
    parameter int          LAT    = 4,
    parameter logic [11:0] BUBBLE = 12'hFF0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        prog_we,
    input  logic [3:0]  prog_addr,
    input  logic [11:0] prog_data,
    input  logic [4:0]  prog_len,
    input  logic        start,
    output logic [11:0] instr,
    input  logic [31:0] core_result,
    output logic [31:0] res_data,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        busy,
    output logic        done
);
    // state | meaning
    // IDLE  | waiting for start; a start with a free credit issues word 0 at once
    // ISSUE | issuing buffer[ptr] on every cycle a credit is free
    // DRAIN | every word issued, waiting for in-flight results to land
    // DONE  | one-cycle done pulse, then back to IDLE
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [11:0] prog_mem [16];
    logic [3:0]  ptr;
    logic [3:0]  ptr_nxt;
    logic [4:0]  len;
    logic [4:0]  len_nxt;
    logic [4:0]  len_sel;
    logic [3:0]  issue_idx;
    logic        issue;
    logic [LAT-1:0] vld;
    logic [7:0]  in_flight;
    logic [7:0]  fill;
    logic        credit_ok;

    logic [31:0] fifo_mem [4];
    logic [1:0]  rd_ptr;
    logic [1:0]  wr_ptr;
    logic [2:0]  count;
    logic        push;
    logic        pop;

    assign busy      = (state == ISSUE) || (state == DRAIN);
    assign done      = (state == DONE);
    assign res_valid = (count != 3'd0);
    assign res_data  = fifo_mem[rd_ptr];
    assign push      = vld[LAT-1];
    assign pop       = res_valid && res_ready;

    always_comb begin
        len_sel = prog_len;
        if (prog_len == 5'd0 || prog_len > 5'd16) begin
            len_sel = 5'd16;
        end
    end

    // Results already in the FIFO plus those still in the core both consume a credit.
    always_comb begin
        in_flight = '0;
        for (int i = 0; i < LAT; i++) begin
            in_flight = in_flight + 8'(vld[i]);
        end
        fill      = in_flight + 8'(count);
        credit_ok = (fill < 8'd4);
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        issue_idx = ptr;
        ptr_nxt   = ptr;
        len_nxt   = len;
        case (state)
            IDLE: begin
                if (start) begin
                    len_nxt   = len_sel;
                    issue_idx = 4'd0;
                    ptr_nxt   = 4'd0;
                    state_nxt = ISSUE;
                    if (credit_ok) begin
                        issue   = 1'b1;
                        ptr_nxt = 4'd1;
                        if (len_sel == 5'd1) begin
                            state_nxt = DRAIN;
                        end
                    end
                end
            end
            ISSUE: begin
                if (credit_ok) begin
                    issue   = 1'b1;
                    ptr_nxt = ptr + 4'd1;
                    if ({1'b0, ptr} == len - 5'd1) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (vld == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= 4'd0;
            len    <= 5'd16;
            vld    <= '0;
            instr  <= BUBBLE;
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            len   <= len_nxt;
            vld   <= (vld << 1) | LAT'(issue);
            instr <= issue ? prog_mem[issue_idx] : BUBBLE;
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage arrays carry no reset; the program survives rst by design.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= core_result;
        end
        if (prog_we && !busy) begin
            prog_mem[prog_addr] <= prog_data;
        end
    end

endmodule

// File: tb/tb_simd_issuer.sv
// Self-checking bench for simd_issuer: a queue-based cycle model predicts issue slots,
// result timing and FIFO contents, and each scenario task compares the DUT against it.
module tb_simd_issuer;
    localparam int          LAT    = 4;
    localparam logic [11:0] BUBBLE = 12'hFF0;

    logic        clk;
    logic        rst;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [11:0] prog_data;
    logic [4:0]  prog_len;
    logic        start;
    logic [11:0] instr;
    logic [31:0] core_result;
    logic [31:0] res_data;
    logic        res_valid;
    logic        res_ready;
    logic        busy;
    logic        done;

    simd_issuer #(.LAT(LAT), .BUBBLE(BUBBLE)) dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_len(prog_len), .start(start), .instr(instr),
        .core_result(core_result), .res_data(res_data), .res_valid(res_valid),
        .res_ready(res_ready), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: 0 idle, 1 issuing, 2 draining, 3 done pulse.
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          m_state = 0;
    int          m_ptr = 0;
    int          m_len = 16;
    logic [11:0] m_prog [16];
    logic [31:0] m_fifo [$];
    int          m_due [$];
    logic [31:0] core_log [int];
    logic [11:0] m_instr;
    logic        m_valid, m_busy, m_done;
    logic [31:0] m_data;

    task automatic tick();
        bit was_busy, do_pop, do_push;
        int credits;
        @(posedge clk);
        core_log[cyc] = core_result;
        was_busy = (m_state == 1) || (m_state == 2);
        if (prog_we && !was_busy) m_prog[prog_addr] = prog_data;
        if (rst) begin
            m_state = 0;
            m_ptr   = 0;
            m_fifo.delete();
            m_due.delete();
            m_instr = BUBBLE;
        end else begin
            credits = 4 - m_fifo.size() - m_due.size();
            do_pop  = (m_fifo.size() > 0) && res_ready;
            do_push = (m_due.size() > 0) && (m_due[0] == cyc);
            m_instr = BUBBLE;
            case (m_state)
                0: if (start) begin
                    m_len   = (prog_len == 0 || prog_len > 16) ? 16 : int'(prog_len);
                    m_ptr   = 0;
                    m_state = 1;
                end
                2: if (m_due.size() == 0) m_state = 3;
                3: m_state = 0;
                default: ;
            endcase
            if (m_state == 1 && credits > 0) begin
                m_instr = m_prog[m_ptr];
                m_due.push_back(cyc + LAT);
                m_ptr++;
                if (m_ptr == m_len) m_state = 2;
            end
            if (do_pop) void'(m_fifo.pop_front());
            if (do_push) begin
                m_fifo.push_back(core_result);
                void'(m_due.pop_front());
            end
        end
        cyc++;
        m_valid = (m_fifo.size() > 0);
        m_data  = m_valid ? m_fifo[0] : 32'h0;
        m_busy  = (m_state == 1) || (m_state == 2);
        m_done  = (m_state == 3);
        #1;
        core_result = $urandom;
    endtask

    function automatic bit model_idle();
        return (m_state == 0) && (m_fifo.size() == 0) && (m_due.size() == 0);
    endfunction

    task automatic load_prog();
        for (int i = 0; i < 16; i++) begin
            prog_we   = 1'b1;
            prog_addr = 4'(i);
            prog_data = 12'($urandom_range(0, 12'hFEF));
            tick();
        end
        prog_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; prog_we = 1'b0; prog_addr = 4'd0; prog_data = 12'd0;
        prog_len = 5'd0; start = 1'b0; res_ready = 1'b0; core_result = $urandom;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if (instr !== BUBBLE || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_instr_busy instr=%h busy=%b want %h 0", instr, busy, BUBBLE);
        end
        checks++;
        if (res_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid_done valid=%b done=%b want 0 0", res_valid, done);
        end
        load_prog();
    endtask

    task automatic test_basic();
        int t0;
        res_ready = 1'b1; prog_len = 5'd3; start = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0;
        for (int t = 1; t <= 12; t++) begin
            checks++;
            if ({instr, res_valid, busy, done} !== {m_instr, m_valid, m_busy, m_done} ||
                (m_valid && res_data !== m_data)) begin
                errors++;
                $display("FAIL basic_model cyc=%0d instr=%h/%h valid=%b/%b busy=%b/%b done=%b/%b data=%h/%h",
                         cyc, instr, m_instr, res_valid, m_valid, busy, m_busy, done, m_done, res_data, m_data);
            end
            checks++;
            if (instr !== ((t >= 1 && t <= 3) ? m_prog[t-1] : BUBBLE)) begin
                errors++;
                $display("FAIL basic_instr t=%0d got %h", t, instr);
            end
            checks++;
            if (res_valid !== (t >= 5 && t <= 7) || done !== (t == 8)) begin
                errors++;
                $display("FAIL basic_timing t=%0d valid=%b done=%b", t, res_valid, done);
            end
            if (t >= 5 && t <= 7) begin
                checks++;
                if (res_data !== core_log[t0 + t - 1]) begin
                    errors++;
                    $display("FAIL basic_data t=%0d got %h want %h", t, res_data, core_log[t0 + t - 1]);
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int n_iss = 0, n_pop = 0, guard = 0;
        res_ready = 1'b0; prog_len = 5'd8; start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < 14; t++) begin
            checks++;
            if ({instr, res_valid, busy, done} !== {m_instr, m_valid, m_busy, m_done} ||
                (m_valid && res_data !== m_data)) begin
                errors++;
                $display("FAIL bp_model cyc=%0d instr=%h/%h valid=%b/%b busy=%b/%b done=%b/%b data=%h/%h",
                         cyc, instr, m_instr, res_valid, m_valid, busy, m_busy, done, m_done, res_data, m_data);
            end
            if (instr !== BUBBLE) n_iss++;
            tick();
        end
        checks++;
        if (n_iss != 4 || res_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_stalled issued=%0d valid=%b want 4 1", n_iss, res_valid);
        end
        res_ready = 1'b1;
        while (!model_idle() && guard < 80) begin
            checks++;
            if ({instr, res_valid, busy, done} !== {m_instr, m_valid, m_busy, m_done} ||
                (m_valid && res_data !== m_data)) begin
                errors++;
                $display("FAIL bp_model cyc=%0d instr=%h/%h valid=%b/%b busy=%b/%b done=%b/%b data=%h/%h",
                         cyc, instr, m_instr, res_valid, m_valid, busy, m_busy, done, m_done, res_data, m_data);
            end
            if (instr !== BUBBLE) n_iss++;
            if (res_valid) n_pop++;
            tick();
            guard++;
        end
        checks++;
        if (guard >= 80 || n_iss != 8 || n_pop != 8) begin
            errors++;
            $display("FAIL bp_totals issued=%0d popped=%0d guard=%0d want 8 8", n_iss, n_pop, guard);
        end
    endtask

    task automatic test_push_pop();
        int t0, n_pop = 0, guard = 0;
        res_ready = 1'b0; prog_len = 5'd3; start = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            res_ready = (t == 6);
            checks++;
            if ({instr, res_valid, busy, done} !== {m_instr, m_valid, m_busy, m_done} ||
                (m_valid && res_data !== m_data)) begin
                errors++;
                $display("FAIL pp_model cyc=%0d instr=%h/%h valid=%b/%b busy=%b/%b done=%b/%b data=%h/%h",
                         cyc, instr, m_instr, res_valid, m_valid, busy, m_busy, done, m_done, res_data, m_data);
            end
            if (t == 7) begin
                checks++;
                if (res_valid !== 1'b1 || res_data !== core_log[t0 + 5]) begin
                    errors++;
                    $display("FAIL pp_oldest valid=%b got %h want %h", res_valid, res_data, core_log[t0 + 5]);
                end
            end
            tick();
        end
        res_ready = 1'b1;
        while (res_valid && guard < 10) begin
            n_pop++;
            tick();
            guard++;
        end
        checks++;
        if (n_pop != 2) begin
            errors++;
            $display("FAIL pp_occupancy popped=%0d want 2", n_pop);
        end
    endtask

    task automatic test_len_zero();
        int n_iss = 0, n_pop = 0, n_done = 0, guard = 0;
        prog_len = 5'd0; start = 1'b1; res_ready = 1'b1;
        tick();
        start = 1'b0;
        while (!model_idle() && guard < 300) begin
            res_ready = ($urandom_range(0, 3) != 0);
            checks++;
            if ({instr, res_valid, busy, done} !== {m_instr, m_valid, m_busy, m_done} ||
                (m_valid && res_data !== m_data)) begin
                errors++;
                $display("FAIL len0_model cyc=%0d instr=%h/%h valid=%b/%b busy=%b/%b done=%b/%b data=%h/%h",
                         cyc, instr, m_instr, res_valid, m_valid, busy, m_busy, done, m_done, res_data, m_data);
            end
            if (instr !== BUBBLE) n_iss++;
            if (res_valid && res_ready) n_pop++;
            if (done) n_done++;
            tick();
            guard++;
        end
        checks++;
        if (guard >= 300 || n_iss != 16 || n_pop != 16 || n_done != 1) begin
            errors++;
            $display("FAIL len0_totals issued=%0d popped=%0d done=%0d guard=%0d want 16 16 1",
                     n_iss, n_pop, n_done, guard);
        end
    endtask

    task automatic test_reset_mid();
        int guard = 0, n_done = 0;
        prog_len = 5'd8; start = 1'b1; res_ready = 1'b1;
        tick();
        start = 1'b0;
        while (!(m_state == 2 && m_due.size() == 2) && guard < 60) begin
            checks++;
            if ({instr, res_valid, busy, done} !== {m_instr, m_valid, m_busy, m_done} ||
                (m_valid && res_data !== m_data)) begin
                errors++;
                $display("FAIL rmid_model cyc=%0d instr=%h/%h valid=%b/%b busy=%b/%b done=%b/%b data=%h/%h",
                         cyc, instr, m_instr, res_valid, m_valid, busy, m_busy, done, m_done, res_data, m_data);
            end
            tick();
            guard++;
        end
        checks++;
        if (guard >= 60 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rmid_reach guard=%0d busy=%b", guard, busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || instr !== 12'hFF0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rmid_after busy=%b valid=%b instr=%h done=%b want 0 0 ff0 0",
                     busy, res_valid, instr, done);
        end
        for (int t = 0; t < 10; t++) begin
            if (done) n_done++;
            if (res_valid) n_done++;
            tick();
        end
        checks++;
        if (n_done != 0) begin
            errors++;
            $display("FAIL rmid_quiet spurious done/valid cycles=%0d want 0", n_done);
        end
    endtask

    task automatic test_prog_lock();
        logic [11:0] old0;
        int guard = 0;
        bit seen = 1'b0;
        old0 = m_prog[0];
        for (int run = 0; run < 2; run++) begin
            prog_len = 5'd4; start = 1'b1; res_ready = 1'b1;
            tick();
            start = 1'b0;
            if (run == 0) begin
                prog_we = 1'b1; prog_addr = 4'd0; prog_data = ~old0;
            end
            guard = 0;
            while (!model_idle() && guard < 60) begin
                checks++;
                if ({instr, res_valid, busy, done} !== {m_instr, m_valid, m_busy, m_done} ||
                    (m_valid && res_data !== m_data)) begin
                    errors++;
                    $display("FAIL lock_model cyc=%0d instr=%h/%h valid=%b/%b busy=%b/%b done=%b/%b data=%h/%h",
                             cyc, instr, m_instr, res_valid, m_valid, busy, m_busy, done, m_done, res_data, m_data);
                end
                if (run == 1 && !seen && instr !== BUBBLE) begin
                    seen = 1'b1;
                    checks++;
                    if (instr !== old0) begin
                        errors++;
                        $display("FAIL lock_word0 got %h want %h", instr, old0);
                    end
                end
                tick();
                prog_we = 1'b0;
                guard++;
            end
        end
        checks++;
        if (!seen || guard >= 60) begin
            errors++;
            $display("FAIL lock_rerun seen=%b guard=%0d", seen, guard);
        end
    endtask

    task automatic test_random();
        int guard;
        for (int run = 0; run < 6; run++) begin
            for (int w = 0; w < 3; w++) begin
                prog_we   = 1'b1;
                prog_addr = 4'($urandom_range(0, 15));
                prog_data = 12'($urandom_range(0, 12'hFEF));
                tick();
            end
            prog_we  = 1'b0;
            prog_len = 5'($urandom_range(0, 31));
            start    = 1'b1;
            tick();
            guard = 0;
            while (!model_idle() && guard < 300) begin
                res_ready = ($urandom_range(0, 2) != 0);
                start     = m_busy && ($urandom_range(0, 3) == 0);
                prog_we   = m_busy && ($urandom_range(0, 3) == 0);
                prog_addr = 4'($urandom_range(0, 15));
                prog_data = 12'($urandom_range(0, 12'hFEF));
                checks++;
                if ({instr, res_valid, busy, done} !== {m_instr, m_valid, m_busy, m_done} ||
                    (m_valid && res_data !== m_data)) begin
                    errors++;
                    $display("FAIL rand_model cyc=%0d instr=%h/%h valid=%b/%b busy=%b/%b done=%b/%b data=%h/%h",
                             cyc, instr, m_instr, res_valid, m_valid, busy, m_busy, done, m_done, res_data, m_data);
                end
                tick();
                guard++;
            end
            start = 1'b0; prog_we = 1'b0;
            checks++;
            if (guard >= 300) begin
                errors++;
                $display("FAIL rand_timeout run=%0d", run);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_push_pop();
        test_len_zero();
        test_reset_mid();
        test_prog_lock();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/simd_issuer.md
SIMD_ISSUER -- requirements
Module: simd_issuer

Interface
REQ-001 SHALL provide the following parameter: LAT, default 4, meaning cycles from instr presentation to matching core_result.
REQ-002 SHALL provide the following parameter: BUBBLE, default 12'hFF0, meaning no-op word driven when no instruction is issued (opcode F, scratch reg 15).
REQ-003 SHALL provide the port: clk  input  1  clock, all logic on rising edge.
REQ-004 SHALL provide the port: rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL provide the port: prog_we  input  1  program-buffer write strobe.
REQ-006 SHALL provide the port: prog_addr  input  4  program-buffer write address.
REQ-007 SHALL provide the port: prog_data  input  12  instruction word to store.
REQ-008 SHALL provide the port: prog_len  input  5  instruction count, 1..16, sampled on start.
REQ-009 SHALL provide the port: start  input  1  one-cycle run request.
REQ-010 SHALL provide the port: instr  output  12  instruction word to the SIMD core, registered.
REQ-011 SHALL provide the port: core_result  input  32  SIMD core output {high half, written register}.
REQ-012 SHALL provide the port: res_data  output  32  captured result at FIFO head.
REQ-013 SHALL provide the port: res_valid  output  1  FIFO non-empty.
REQ-014 SHALL provide the port: res_ready  input  1  consumer accepts res_data.
REQ-015 SHALL provide the port: busy  output  1  run in progress.
REQ-016 SHALL provide the port: done  output  1  one-cycle pulse when the last result is captured.

Function
REQ-017 SHALL hold a 16x12 program buffer; a prog_we write takes effect at the clock edge and is ignored while busy=1.
REQ-018 SHALL implement FSM states IDLE, ISSUE, DRAIN, DONE.
REQ-019 SHALL, in IDLE, on start=1, latch prog_len, clear the issue pointer and enter ISSUE; start is ignored in all other states.
REQ-020 SHALL treat prog_len values 0 or greater than 16 as 16.
REQ-021 SHALL, in ISSUE, drive instr=buffer[ptr] and increment ptr each cycle a credit is available, and SHALL otherwise drive instr=BUBBLE.
REQ-022 SHALL define credits = 4 - (FIFO occupancy + in-flight count), and SHALL issue only when credits>0, so that the FIFO never overflows.
REQ-023 SHALL track in-flight instructions with a LAT-deep valid shift register, shifting 1 for an issued cycle and 0 for a bubble cycle.
REQ-024 SHALL, for an instr presented during cycle N, push core_result into the FIFO at the edge ending cycle N+LAT.
REQ-025 SHALL never push results of bubble cycles into the FIFO.
REQ-026 SHALL transition ISSUE -> DRAIN when the last instruction issues.
REQ-027 SHALL transition DRAIN -> DONE when the last valid bit retires.
REQ-028 SHALL pulse done=1 for one cycle in DONE, then return to IDLE.
REQ-029 SHALL drive busy=1 in ISSUE and DRAIN.
REQ-030 SHALL implement the result FIFO as 4 entries, first-word-fall-through.
REQ-031 SHALL pop the FIFO when res_valid&&res_ready.
REQ-032 SHALL, on simultaneous push and pop, leave occupancy unchanged with data order preserved.
REQ-033 SHALL wrap the FIFO pointers mod 4.
REQ-034 SHALL allow FIFO entries to persist after done until read.
REQ-035 SHALL allow a new start in IDLE while the FIFO is non-empty, with credits still enforced.

Reset
REQ-036 SHALL, while rst=1 at an edge, set state=IDLE, instr=BUBBLE, busy=0, done=0, res_valid=0, FIFO empty, valid shift register cleared, ptr=0.
REQ-037 SHALL leave program buffer contents unchanged by reset.
REQ-038 SHALL, on reset asserted mid-run, discard in-flight results and not generate a done pulse.

Verification
REQ-039 SHALL be verified by: load 3 words, prog_len=3, start, res_ready=1 -> instr shows words on cycles 1-3 then BUBBLE; res_valid in cycles 5-7 carrying core_result of those cycles; done at cycle 8.
REQ-040 SHALL be verified by: prog_len=8, res_ready=0 -> exactly 4 instructions issue, then BUBBLE; FIFO full, 4 entries; release res_ready -> remaining 4 issue, all 8 results delivered in order.
REQ-041 SHALL be verified by: FIFO at 2 entries, push and pop in the same cycle -> occupancy stays 2; next res_data is the oldest entry.
REQ-042 SHALL be verified by: prog_len=0 -> 16 instructions issued, 16 results, a single done pulse.
REQ-043 SHALL be verified by: rst asserted in DRAIN with 2 in flight -> next cycle busy=0, res_valid=0, instr=12'hFF0, no done pulse; buffer still holds the loaded words.
REQ-044 SHALL be verified by: prog_we pulsed while busy with prog_addr=0 -> buffer[0] unchanged, confirmed by a rerun.
